// File: rtl/avalon_mem_copier.sv
// Avalon-MM block copier: moves len_words 32-bit words from src_addr to dst_addr,
// one read then one write per word. Define MEMCOPY_FILL_EN to build the pattern-fill mode.
module avalon_mem_copier #(
  parameter int ADDR_W = 17,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              start_fill,
  input  logic [31:0]       fill_pattern,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
`ifdef MEMCOPY_FILL_EN
    S_FILL_WR = 3'd4,
`endif
    S_FIN     = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LP_WORD_STEP = ADDR_W'(3'd4);
  localparam logic [LEN_W-1:0]  LP_LEN_ONE   = LEN_W'(1'b1);
  localparam logic [LEN_W-1:0]  LP_LEN_ZERO  = {LEN_W{1'b0}};

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] w_src;
  logic [ADDR_W-1:0] w_dst;
  logic [ADDR_W-1:0] w_src_aligned;
  logic [ADDR_W-1:0] w_dst_aligned;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_cnt;
  logic [31:0]       r_wdata;
  logic [31:0]       w_wdata;
  logic              w_last_word;

  logic [ADDR_W-1:0] r_avm_address;
  logic [ADDR_W-1:0] w_avm_address;
  logic              r_avm_read;
  logic              r_avm_write;
  logic              r_busy;
  logic              r_done;
  logic              w_read_next;
  logic              w_write_next;
  logic              w_busy_next;
  logic              w_done_next;
  logic              w_unused;

  assign w_src_aligned = {src_addr[ADDR_W-1:2], 2'b00};
  assign w_dst_aligned = {dst_addr[ADDR_W-1:2], 2'b00};
  assign w_last_word   = ((r_cnt + LP_LEN_ONE) == r_len);

`ifdef MEMCOPY_FILL_EN
  assign w_unused = ^{src_addr[1:0], dst_addr[1:0]};
`else
  assign w_unused = ^{src_addr[1:0], dst_addr[1:0], start_fill, fill_pattern};
`endif

  // Next-state and working-register update for the transfer sequencer.
  always_comb begin
    w_next_state = r_state;
    w_src        = r_src;
    w_dst        = r_dst;
    w_len        = r_len;
    w_cnt        = r_cnt;
    w_wdata      = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src = w_src_aligned;
          w_dst = w_dst_aligned;
          w_len = len_words;
          w_cnt = LP_LEN_ZERO;
          if (len_words == LP_LEN_ZERO) begin
            w_next_state = S_FIN;
          end else begin
            w_next_state = S_RD_REQ;
          end
        end
`ifdef MEMCOPY_FILL_EN
        else if (start_fill) begin
          w_dst   = w_dst_aligned;
          w_len   = len_words;
          w_cnt   = LP_LEN_ZERO;
          w_wdata = fill_pattern;
          if (len_words == LP_LEN_ZERO) begin
            w_next_state = S_FIN;
          end else begin
            w_next_state = S_FILL_WR;
          end
        end
`endif
        else begin
          w_next_state = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (!avm_waitrequest) begin
          w_next_state = S_RD_WAIT;
        end else begin
          w_next_state = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          w_wdata      = avm_readdata;
          w_next_state = S_WR_REQ;
        end else begin
          w_next_state = S_RD_WAIT;
        end
      end
      S_WR_REQ: begin
        if (!avm_waitrequest) begin
          // Address arithmetic wraps silently at 2^ADDR_W.
          w_src = r_src + LP_WORD_STEP;
          w_dst = r_dst + LP_WORD_STEP;
          w_cnt = r_cnt + LP_LEN_ONE;
          if (w_last_word) begin
            w_next_state = S_FIN;
          end else begin
            w_next_state = S_RD_REQ;
          end
        end else begin
          w_next_state = S_WR_REQ;
        end
      end
`ifdef MEMCOPY_FILL_EN
      S_FILL_WR: begin
        if (!avm_waitrequest) begin
          w_dst = r_dst + LP_WORD_STEP;
          w_cnt = r_cnt + LP_LEN_ONE;
          if (w_last_word) begin
            w_next_state = S_FIN;
          end else begin
            w_next_state = S_FILL_WR;
          end
        end else begin
          w_next_state = S_FILL_WR;
        end
      end
`endif
      S_FIN: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Bus and status values for the coming cycle, decoded from the next state so they can be registered.
  always_comb begin
    w_read_next   = 1'b0;
    w_write_next  = 1'b0;
    w_busy_next   = 1'b0;
    w_done_next   = 1'b0;
    w_avm_address = r_avm_address;
    case (w_next_state)
      S_RD_REQ: begin
        w_read_next   = 1'b1;
        w_busy_next   = 1'b1;
        w_avm_address = w_src;
      end
      S_RD_WAIT: begin
        w_busy_next = 1'b1;
      end
      S_WR_REQ: begin
        w_write_next  = 1'b1;
        w_busy_next   = 1'b1;
        w_avm_address = w_dst;
      end
`ifdef MEMCOPY_FILL_EN
      S_FILL_WR: begin
        w_write_next  = 1'b1;
        w_busy_next   = 1'b1;
        w_avm_address = w_dst;
      end
`endif
      S_FIN: begin
        w_done_next = 1'b1;
      end
      default: begin
        w_busy_next = 1'b0;
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_src         <= {ADDR_W{1'b0}};
      r_dst         <= {ADDR_W{1'b0}};
      r_len         <= LP_LEN_ZERO;
      r_cnt         <= LP_LEN_ZERO;
      r_wdata       <= 32'h0000_0000;
      r_avm_address <= {ADDR_W{1'b0}};
      r_avm_read    <= 1'b0;
      r_avm_write   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_src         <= w_src;
      r_dst         <= w_dst;
      r_len         <= w_len;
      r_cnt         <= w_cnt;
      r_wdata       <= w_wdata;
      r_avm_address <= w_avm_address;
      r_avm_read    <= w_read_next;
      r_avm_write   <= w_write_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign words_done     = r_cnt;
  assign avm_address    = r_avm_address;
  assign avm_read       = r_avm_read;
  assign avm_write      = r_avm_write;
  assign avm_byteenable = 4'hF;
  assign avm_writedata  = r_wdata;

endmodule

// File: tb/tb_avalon_mem_copier.sv
// Self-checking bench for avalon_mem_copier: directed and randomized transfers against
// a word-array reference model, with a latency-1 Avalon slave that can insert wait states.
module tb_avalon_mem_copier;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        start_fill = 1'b0;
  logic [16:0] src_addr = 17'h0;
  logic [16:0] dst_addr = 17'h0;
  logic [14:0] len_words = 15'h0;
  logic [31:0] fill_pattern = 32'h0;
  logic        busy, done;
  logic [14:0] words_done;
  logic [16:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalon_mem_copier #(.ADDR_W(17), .LEN_W(15)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .start_fill(start_fill), .fill_pattern(fill_pattern),
    .busy(busy), .done(done), .words_done(words_done), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave memory model ----------------
  logic [31:0] seed = 32'h0;
  logic [31:0] mem [0:32767];
  bit          written [0:32767];
  logic [31:0] ref_mem [0:32767];
  int          wait_cfg = 0;
  int          stall_cnt;
  bit          spur_en = 1'b0;
  logic [16:0] rd_log[$];
  logic [16:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  function automatic logic [31:0] init_word(input logic [14:0] idx);
    return ({17'h0, idx} * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [31:0] slave_word(input logic [14:0] idx);
    return written[idx] ? mem[idx] : init_word(idx);
  endfunction

  assign avm_waitrequest = (avm_read || avm_write) && (stall_cnt < wait_cfg);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt         <= 0;
      avm_readdatavalid <= 1'b0;
      avm_readdata      <= 32'h0;
    end else if ((avm_read || avm_write) && avm_waitrequest) begin
      stall_cnt         <= stall_cnt + 1;
      avm_readdatavalid <= 1'b0;
    end else if (avm_read) begin
      stall_cnt         <= 0;
      avm_readdatavalid <= 1'b1;
      avm_readdata      <= slave_word(avm_address[16:2]);
      rd_log.push_back(avm_address);
    end else begin
      if (avm_write) begin
        stall_cnt                  <= 0;
        mem[avm_address[16:2]]     <= avm_writedata;
        written[avm_address[16:2]] <= 1'b1;
        wr_addr_log.push_back(avm_address);
        wr_data_log.push_back(avm_writedata);
      end
      // Stray readdatavalid pulses with junk data must be ignored outside the read-wait phase.
      if (spur_en) begin
        avm_readdatavalid <= 1'($urandom_range(0, 1));
        avm_readdata      <= $urandom;
      end else begin
        avm_readdatavalid <= 1'b0;
      end
    end
  end

  // ---------------- bus protocol monitor ----------------
  bit          p_stall = 1'b0;
  logic [50:0] p_bus;
  int          req_cycles = 0;
  int          done_pulses = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      p_stall <= 1'b0;
    end else begin
      chk("rw_exclusive", 64'(avm_read && avm_write), 64'h0);
      if (p_stall) chk("stall_hold", 64'({avm_address, avm_read, avm_write, avm_writedata}), 64'(p_bus));
      if (avm_read || avm_write) req_cycles++;
      if (done) done_pulses++;
      p_stall <= (avm_read || avm_write) && avm_waitrequest;
      p_bus   <= {avm_address, avm_read, avm_write, avm_writedata};
    end
  end

  function automatic string hx(input logic [16:0] a);
    return $sformatf("%05h", a);
  endfunction

  // One command from strobe to completion, checked against the reference model.
  task automatic run_cmd(input string tag, input bit fill, input bit both, input logic [16:0] s,
                         input logic [16:0] d, input logic [14:0] n, input logic [31:0] pat, input int w);
    logic [16:0] sa, da, sa0, da0;
    logic [16:0] e_rd[$];
    logic [16:0] e_addr[$];
    logic [31:0] e_data[$];
    int cyc, exp_done;
    sa = {s[16:2], 2'b00};
    da = {d[16:2], 2'b00};
    sa0 = sa;
    da0 = da;
    for (int i = 0; i < int'(n); i++) begin
      if (fill) ref_mem[da[16:2]] = pat;
      else begin
        e_rd.push_back(sa);
        ref_mem[da[16:2]] = ref_mem[sa[16:2]];
      end
      e_addr.push_back(da);
      e_data.push_back(ref_mem[da[16:2]]);
      sa = sa + 17'd4;
      da = da + 17'd4;
    end
    exp_done = fill ? 1 + int'(n) * (1 + w) : 1 + int'(n) * (3 + 2 * w);
    wait_cfg = w;
    @(negedge clk);
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    req_cycles = 0; done_pulses = 0;
    src_addr = s; dst_addr = d; len_words = n; fill_pattern = pat;
    start = !fill || both;
    start_fill = fill || both;
    @(negedge clk);
    start = 1'b0; start_fill = 1'b0; cyc = 1;
    chk({tag, "_busy_c1"}, 64'(busy), 64'(n != 15'd0));
    chk({tag, "_req_c1"}, 64'(fill ? avm_write : avm_read), 64'(n != 15'd0));
    if (n != 15'd0) chk({tag, "_addr_c1"}, 64'(avm_address), 64'(fill ? da0 : sa0));
    while (done !== 1'b1 && cyc < exp_done + 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2 && exp_done > 3) begin
        start = 1'b1;
        len_words = 15'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'h0);
    chk({tag, "_words_done"}, 64'(words_done), 64'(n));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'({done, busy}), 64'h0);
    chk({tag, "_done_pulses"}, 64'(done_pulses), 64'h1);
    chk({tag, "_wr_count"}, 64'(wr_addr_log.size()), 64'(n));
    chk({tag, "_rd_count"}, 64'(rd_log.size()), 64'(e_rd.size()));
    for (int i = 0; i < e_addr.size() && i < wr_addr_log.size(); i++) begin
      chk({tag, "_wr_addr"}, 64'(wr_addr_log[i]), 64'(e_addr[i]));
      chk({tag, "_wr_data@", hx(e_addr[i])}, 64'(wr_data_log[i]), 64'(e_data[i]));
    end
    for (int i = 0; i < e_rd.size() && i < rd_log.size(); i++)
      chk({tag, "_rd_addr"}, 64'(rd_log[i]), 64'(e_rd[i]));
    if (n == 15'd0) chk({tag, "_no_bus_cycles"}, 64'(req_cycles), 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    seed = $urandom;
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(15'(i));

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, words_done, avm_address, avm_read, avm_write, avm_writedata}), 64'h0);
    chk("reset_byteenable", 64'(avm_byteenable), 64'hF);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd("copy_w0", 1'b0, 1'b0, 17'h00100, 17'h00200, 15'd4, 32'h0, 0);
    run_cmd("copy_w2", 1'b0, 1'b0, 17'h00101, 17'h00302, 15'd4, 32'h0, 2);
    run_cmd("len0", 1'b0, 1'b0, 17'h00400, 17'h00500, 15'd0, 32'h0, 0);
    run_cmd("wrap", 1'b0, 1'b0, 17'h1FFFC, 17'h00800, 15'd2, 32'h0, 0);
    if (rd_log.size() > 1) chk("wrap_second_read", 64'(rd_log[1]), 64'h0);
    run_cmd("both_strobes", 1'b0, 1'b1, 17'h00900, 17'h00A00, 15'd2, 32'h1234_5678, 0);

    // Reset during the second word's write
    wait_cfg = 0;
    @(negedge clk);
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); done_pulses = 0;
    src_addr = 17'h00C00; dst_addr = 17'h00D00; len_words = 15'd4; start = 1'b1;
    ref_mem[15'h0340] = ref_mem[15'h0300];
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 6) begin @(negedge clk); cyc++; end
    chk("abort_in_write", 64'({avm_write, avm_address}), 64'({1'b1, 17'h00D04}));
    chk("abort_words_done_before", 64'(words_done), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs_zero", 64'({busy, done, words_done, avm_address, avm_read, avm_write, avm_writedata}), 64'h0);
    chk("abort_byteenable", 64'(avm_byteenable), 64'hF);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 64'(done_pulses), 64'h0);
    chk("abort_idle", 64'({busy, words_done, avm_read, avm_write}), 64'h0);
    chk("abort_wr_count", 64'(wr_addr_log.size()), 64'h1);
    run_cmd("after_abort", 1'b0, 1'b0, 17'h00E00, 17'h00F00, 15'd3, 32'h0, 0);

`ifdef MEMCOPY_FILL_EN
    run_cmd("fill", 1'b1, 1'b0, 17'h00000, 17'h00040, 15'd3, 32'hDEAD_BEEF, 0);
    run_cmd("fill_w1", 1'b1, 1'b0, 17'h00000, 17'h01000, 15'd5, $urandom, 1);
    run_cmd("fill_len0", 1'b1, 1'b0, 17'h00000, 17'h01100, 15'd0, 32'h0, 0);
`else
    @(negedge clk);
    req_cycles = 0; done_pulses = 0;
    dst_addr = 17'h00040; len_words = 15'd3; fill_pattern = 32'hDEAD_BEEF; start_fill = 1'b1;
    @(negedge clk);
    start_fill = 1'b0;
    chk("fill_ignored_busy", 64'(busy), 64'h0);
    repeat (5) @(negedge clk);
    chk("fill_ignored_bus", 64'(req_cycles), 64'h0);
    chk("fill_ignored_done", 64'(done_pulses), 64'h0);
`endif

    // Randomized copies with wait states, stray readdatavalid, overlap and wrap
    spur_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run_cmd($sformatf("rand%0d", k), 1'b0, 1'b0, 17'($urandom), 17'($urandom),
              15'($urandom_range(1, 6)), 32'h0, int'($urandom_range(0, 2)));
    end
    spur_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_mem_copier.md
# avalon_mem_copier

Avalon-MM master that copies a block of 32-bit words from one address range to another over the system interconnect. It is the initiator-side counterpart to the on-chip memory slaves in this design and is typically connected to the interconnect ahead of the `MEMMaster` RAM. It is started by a simple start/done command interface from a control register file or CPU-side glue. It issues one read and one write per word, honours `waitrequest`, and accepts read data on `readdatavalid`.

## Interface
Parameters:
- ADDR_W, 17: Avalon byte-address width; bits [1:0] are driven 0.
- LEN_W, 15: width of the word-count field.

Ports (clock and reset first):
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe, sampled only in IDLE.
- src_addr  in  ADDR_W  source byte address; bits [1:0] are ignored.
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] are ignored.
- len_words  in  LEN_W  number of words to transfer.
- start_fill  in  1  fill command strobe (only active with `MEMCOPY_FILL_EN`).
- fill_pattern  in  32  word written in fill mode.
- busy  out  1  high from the cycle after an accepted command until `done`.
- done  out  1  one-cycle pulse when the transfer completes.
- words_done  out  LEN_W  number of writes accepted so far in the current transfer.
- avm_address  out  ADDR_W  master address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_byteenable  out  4  constant 4'hF.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data valid.
- avm_waitrequest  in  1  slave stall.

## Operation
States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FILL_WR, FIN.
- **IDLE**
  - When `start` is high: latch the word-aligned src/dst addresses and `len_words`, and clear `words_done`.
  - If len = 0, go to FIN. Otherwise go to RD_REQ.
  - `start` and `start_fill` together: `start` wins.
- **RD_REQ**
  - `avm_read` = 1 and `avm_address` = current src address.
  - Hold the address and `avm_read` while `avm_waitrequest` = 1.
  - On the cycle with `waitrequest` = 0, go to RD_WAIT.
- **RD_WAIT**
  - `avm_read` = 0.
  - On `avm_readdatavalid`, capture `avm_readdata` into the write-data register and go to WR_REQ.
- **WR_REQ**
  - `avm_write` = 1, `avm_address` = current dst address, `avm_writedata` = captured word.
  - Hold all of these while `waitrequest` = 1.
  - On acceptance:
    - src += 4 and dst += 4, both modulo 2^ADDR_W (wrap silently).
    - `words_done` += 1.
    - If `words_done` + 1 = len, go to FIN. Otherwise go to RD_REQ.
- **FILL_WR** (`MEMCOPY_FILL_EN` only)
  - Writes `fill_pattern` (latched at the command) to the dst address and back-to-back addresses.
  - Each accepted write advances the address and the count.
  - Go to FIN when the last word is accepted.
- **FIN**
  - `done` = 1 for exactly one cycle, then return to IDLE.
  - `busy` is low in FIN.

Rules:
- `avm_read` and `avm_write` are never both high.
- At most one read is outstanding at any time.
- `readdatavalid` outside RD_WAIT is ignored.
- Commands arriving while not in IDLE are ignored.

Reset (async assert, sync release):
- Returns to IDLE.
- All outputs are 0, except `avm_byteenable` = 4'hF.
- A reset in the middle of a transfer abandons it: no `done` pulse is produced, and `words_done` = 0.

## Timing
- Start to first `avm_read`: 1 cycle (`start` in cycle 0, `avm_read` in cycle 1).
- Copy throughput with zero wait states and read latency 1: 3 cycles per word (read accept, readdatavalid, write accept).
- Fill throughput with zero wait states: 1 cycle per word.
- `done` is asserted the cycle after the last write is accepted.
- For len = 0, `done` is asserted in cycle 1 and no bus cycles are issued.
- Every wait-state cycle adds exactly one cycle.
- All outputs are registered.

## Configuration
- `MEMCOPY_FILL_EN` defined:
  - `start_fill` in IDLE with len ≠ 0 enters FILL_WR.
  - `start_fill` with len = 0 goes straight to FIN.
- Macro not defined:
  - `start_fill` and `fill_pattern` are ignored and remain unconnected internally.
  - The FILL_WR state is not built.

## Test plan
- **Copy, zero wait:** src = 0x100, dst = 0x200, len = 4, slave with read latency 1 → writes to 0x200 through 0x20C match source data; `done` pulses at cycle 13; `words_done` = 4.
- **Wait states:** as above, with `waitrequest` held for 2 cycles on every read and every write → address and control are stable while stalled; `done` at cycle 29; data is correct.
- **len = 0:** → `done` at cycle 1; `avm_read` and `avm_write` never assert.
- **Wrap:** src = 0x1FFFC, len = 2 → second read address is 0x00000.
- **Reset mid-transfer:** `reset_n` driven low during WR_REQ of word 2 → all outputs 0 immediately; a new `start` afterwards works normally.
- **Fill (`MEMCOPY_FILL_EN` defined):** `start_fill`, dst = 0x40, len = 3, pattern 0xDEADBEEF → three consecutive writes in cycles 1–3 with no reads, then `done` at cycle 4.
